// File: rtl/uart_tx_arb.sv
// uart_tx_arb: round-robin arbiter that lets NREQ byte sources share one UART
// transmitter. A grant latches the winner's byte into din and raises din_rdy
// and the winner's ack for one cycle. The FSM then waits for the transmitter
// to go busy and to come back idle. If the transmitter never starts, the byte
// is dropped and timeout pulses.
module uart_tx_arb #(
  parameter int NREQ    = 4,
  parameter int IDW     = 2,
  parameter int BUSY_TO = 1023
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NREQ-1:0]   req_valid,
  input  logic [8*NREQ-1:0] req_data,
  output logic [NREQ-1:0]   req_ack,
  output logic [7:0]        din,
  output logic              din_rdy,
  input  logic              tx_rdy,
  output logic [IDW-1:0]    grant_id,
  output logic              busy,
  output logic              timeout
);

  localparam int CNT_W = (BUSY_TO < 1) ? 1 : $clog2(BUSY_TO + 1);
  // The din_rdy cycle counts as the first waited cycle, so the last
  // WAIT_BUSY cycle is reached with the counter at BUSY_TO-2. Timeout then
  // shows BUSY_TO cycles after din_rdy.
  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'((BUSY_TO >= 2) ? BUSY_TO - 2 : 0);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_BUSY, WAIT_DONE} state_t;

  state_t           state;
  logic [IDW-1:0]   last_grant;
  logic [CNT_W-1:0] wait_cnt;
  logic [IDW-1:0]   pick;
  logic [7:0]       pick_byte;

  // Round-robin search beginning one past the previous grantee, wrapping mod NREQ.
  function automatic logic [IDW-1:0] rr_pick(input logic [NREQ-1:0] v,
                                             input logic [IDW-1:0]  last);
    logic [IDW-1:0]  sel;
    logic [NREQ-1:0] sh;
    int              idx;
    sel = '0;
    // Walk from farthest to nearest so the nearest pending requester wins.
    for (int k = NREQ; k >= 1; k--) begin
      idx = (int'(last) + k) % NREQ;
      sh  = v >> idx;
      if (sh[0]) sel = IDW'(idx);
    end
    return sel;
  endfunction

  // Extract requester id's byte from the packed data bus.
  function automatic logic [7:0] byte_of(input logic [8*NREQ-1:0] d,
                                         input logic [IDW-1:0]    id);
    logic [8*NREQ-1:0] sh;
    sh = d >> (8 * int'(id));
    return sh[7:0];
  endfunction

  // Candidate grantee and its byte, evaluated every cycle and used only in IDLE.
  always_comb begin
    pick      = rr_pick(req_valid, last_grant);
    pick_byte = byte_of(req_data, pick);
  end

  // Arbitration FSM with registered outputs. The strobes default low every cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      din        <= '0;
      din_rdy    <= 1'b0;
      req_ack    <= '0;
      grant_id   <= '0;
      busy       <= 1'b0;
      timeout    <= 1'b0;
      last_grant <= IDW'(NREQ - 1);
      wait_cnt   <= '0;
    end else begin
      din_rdy <= 1'b0;
      req_ack <= '0;
      timeout <= 1'b0;
      case (state)
        IDLE: begin
          if (tx_rdy && (|req_valid)) begin
            grant_id   <= pick;
            last_grant <= pick;
            din        <= pick_byte;
            din_rdy    <= 1'b1;
            req_ack    <= NREQ'(1) << pick;
            busy       <= 1'b1;
            state      <= ISSUE;
          end
        end
        ISSUE: begin
          wait_cnt <= '0;
          state    <= WAIT_BUSY;
        end
        WAIT_BUSY: begin
          if (!tx_rdy) begin
            state <= WAIT_DONE;
          end else if (wait_cnt == TO_LAST) begin
            timeout <= 1'b1;
            busy    <= 1'b0;
            state   <= IDLE;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        WAIT_DONE: begin
          if (tx_rdy) begin
            busy  <= 1'b0;
            state <= IDLE;
          end
        end
        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_arb.sv
// Bench for uart_tx_arb. It uses a table of single-grant vectors, then runs
// hand-written sequences for round-robin, transmitter stall, timeout, reset
// abort and data hold. Each expected grant is queued when stimulus is applied
// and is checked when din_rdy appears.
module tb_uart_tx_arb;

  localparam int NREQ = 4;
  localparam int IDW  = 2;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [NREQ-1:0]   req_valid = '0;
  logic [8*NREQ-1:0] req_data = '0;
  logic [NREQ-1:0]   req_ack;
  logic [7:0]        din;
  logic              din_rdy;
  logic              tx_rdy = 1'b1;
  logic [IDW-1:0]    grant_id;
  logic              busy;
  logic              timeout;

  uart_tx_arb #(.NREQ(NREQ), .IDW(IDW), .BUSY_TO(8)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_data(req_data),
    .req_ack(req_ack), .din(din), .din_rdy(din_rdy), .tx_rdy(tx_rdy),
    .grant_id(grant_id), .busy(busy), .timeout(timeout)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0] id;
    logic [7:0] d;
  } exp_t;

  typedef struct {
    logic [3:0]  v;
    logic [31:0] data;
    logic [1:0]  id;
    logic [7:0]  d;
  } vec_t;

  exp_t sb[$];
  vec_t tbl[8];

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int n_rdy = 0;
  int n_to = 0;
  int tx_cnt = 0;
  bit tx_dead = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%0h exp=%0h", name, act, exp);
    end
  endtask

  // One clock. The transmitter model runs here: 10 busy cycles per din_rdy
  // unless tx_dead is set. The scoreboard also checks each din_rdy here.
  task automatic step();
    exp_t e;
    @(posedge clk);
    #1;
    cyc++;
    if (tx_cnt > 0) begin
      tx_cnt--;
      if (tx_cnt == 0) tx_rdy = 1'b1;
    end else if (din_rdy && !tx_dead) begin
      tx_rdy = 1'b0;
      tx_cnt = 10;
    end
    if (timeout) n_to++;
    if (din_rdy) begin
      n_rdy++;
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL sb_unexpected din=%0h gid=%0d", din, grant_id);
      end else begin
        e = sb.pop_front();
        chk("sb_din", 32'(din), 32'(e.d));
        chk("sb_gid", 32'(grant_id), 32'(e.id));
        chk("sb_ack", 32'(req_ack), 32'(4'b0001 << e.id));
      end
    end else if (req_ack != '0) begin
      checks++;
      errors++;
      $display("FAIL stray_ack act=%b exp=0000", req_ack);
    end
  endtask

  task automatic wait_rdy(input int lim, output int lat);
    int target;
    target = n_rdy + 1;
    lat = 0;
    while (n_rdy < target && lat < lim) begin
      step();
      lat++;
    end
    if (n_rdy < target) begin
      checks++;
      errors++;
      $display("FAIL wait_rdy_timeout act=none exp=din_rdy within %0d", lim);
    end
  endtask

  task automatic wait_idle(input int lim);
    int k;
    k = 0;
    while (busy && k < lim) begin
      step();
      k++;
    end
    chk("idle_reached", 32'(busy), 32'd0);
  endtask

  initial begin
    int lat;
    int t0;
    int k;
    int base;

    tbl[0] = '{4'b0001, 32'h0000_0055, 2'd0, 8'h55};
    tbl[1] = '{4'b0110, 32'h1122_3344, 2'd1, 8'h33};
    tbl[2] = '{4'b0110, 32'h1122_3344, 2'd2, 8'h22};
    tbl[3] = '{4'b1001, 32'hA1B2_C3D4, 2'd3, 8'hA1};
    tbl[4] = '{4'b1001, 32'hA1B2_C3D4, 2'd0, 8'hD4};
    tbl[5] = '{4'b0100, 32'h0F1E_2D3C, 2'd2, 8'h1E};
    tbl[6] = '{4'b0011, 32'h5A6B_7C8D, 2'd0, 8'h8D};
    tbl[7] = '{4'b1110, 32'h5A6B_7C8D, 2'd1, 8'h7C};

    // Reset with requests pending and the transmitter idle. Nothing may be granted.
    rst = 1'b1;
    req_valid = 4'b1111;
    req_data = 32'hFFFF_FFFF;
    repeat (3) step();
    chk("rst_din", 32'(din), 32'd0);
    chk("rst_din_rdy", 32'(din_rdy), 32'd0);
    chk("rst_ack", 32'(req_ack), 32'd0);
    chk("rst_gid", 32'(grant_id), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_timeout", 32'(timeout), 32'd0);
    req_valid = '0;
    rst = 1'b0;
    step();

    // Table-driven single grants that walk the round-robin pointer.
    for (int i = 0; i < 8; i++) begin
      req_valid = tbl[i].v;
      req_data  = tbl[i].data;
      sb.push_back('{tbl[i].id, tbl[i].d});
      wait_rdy(20, lat);
      chk("tbl_latency", 32'(lat), 32'd1);
      req_valid = '0;
      wait_idle(60);
      chk("tbl_gid_hold", 32'(grant_id), 32'(tbl[i].id));
    end

    // All four requesters held. Grants rotate 0,1,2,3,0 with one ack each.
    rst = 1'b1;
    step();
    rst = 1'b0;
    req_valid = 4'b1111;
    req_data = 32'hA3A2_A1A0;
    sb.push_back('{2'd0, 8'hA0});
    sb.push_back('{2'd1, 8'hA1});
    sb.push_back('{2'd2, 8'hA2});
    sb.push_back('{2'd3, 8'hA3});
    sb.push_back('{2'd0, 8'hA0});
    base = n_rdy;
    k = 0;
    while (n_rdy < base + 5 && k < 300) begin
      step();
      k++;
    end
    req_valid = '0;
    chk("rr_count", 32'(n_rdy - base), 32'd5);
    wait_idle(60);

    // A stalled transmitter blocks grants. Once tx_rdy rises, the grant comes at the next edge.
    req_valid = 4'b0010;
    req_data = 32'h0000_B100;
    tx_rdy = 1'b0;
    base = n_rdy;
    repeat (6) step();
    chk("stall_no_rdy", 32'(n_rdy - base), 32'd0);
    chk("stall_not_busy", 32'(busy), 32'd0);
    tx_rdy = 1'b1;
    sb.push_back('{2'd1, 8'hB1});
    wait_rdy(20, lat);
    chk("stall_latency", 32'(lat), 32'd1);
    req_valid = '0;
    wait_idle(60);

    // Transmitter never starts. Timeout pulses once, 8 cycles after din_rdy.
    tx_dead = 1'b1;
    req_valid = 4'b0100;
    req_data = 32'hC3C2_C1C0;
    sb.push_back('{2'd2, 8'hC2});
    base = n_to;
    wait_rdy(20, lat);
    req_valid = '0;
    t0 = cyc;
    k = 0;
    while (!timeout && k < 20) begin
      step();
      k++;
    end
    chk("to_offset", 32'(cyc - t0), 32'd8);
    chk("to_busy_low", 32'(busy), 32'd0);
    step();
    chk("to_one_cycle", 32'(timeout), 32'd0);
    repeat (10) step();
    chk("to_count", 32'(n_to - base), 32'd1);
    tx_dead = 1'b0;

    // Reset during WAIT_DONE aborts the transfer. The next grant follows the fresh pointer.
    req_valid = 4'b0001;
    req_data = 32'h0000_00E0;
    sb.push_back('{2'd0, 8'hE0});
    wait_rdy(20, lat);
    req_valid = '0;
    repeat (3) step();
    rst = 1'b1;
    step();
    chk("abort_din", 32'(din), 32'd0);
    chk("abort_din_rdy", 32'(din_rdy), 32'd0);
    chk("abort_ack", 32'(req_ack), 32'd0);
    chk("abort_gid", 32'(grant_id), 32'd0);
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_timeout", 32'(timeout), 32'd0);
    rst = 1'b0;
    tx_cnt = 0;
    tx_rdy = 1'b1;
    req_valid = 4'b1000;
    req_data = 32'hE300_0000;
    sb.push_back('{2'd3, 8'hE3});
    wait_rdy(20, lat);
    chk("abort_regrant_lat", 32'(lat), 32'd1);
    req_valid = '0;
    wait_idle(60);

    // Requester 2 changes its byte right after the grant. din keeps the sampled byte.
    req_valid = 4'b0100;
    req_data = 32'h00D2_0000;
    sb.push_back('{2'd2, 8'hD2});
    wait_rdy(20, lat);
    req_data = 32'h00FF_0000;
    req_valid = '0;
    repeat (2) step();
    chk("hold_din_early", 32'(din), 32'hD2);
    wait_idle(60);
    chk("hold_din_idle", 32'(din), 32'hD2);

    chk("sb_drained", 32'(sb.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
